// File: rtl/cim_seq_pkg.sv
// Shared encodings and geometry for the CIM macro sequencer.
package cim_seq_pkg;
    localparam int ADC_BITS = 4;
    localparam int N_COLS   = 16;
    localparam int N_ROWS   = 16;
    localparam int RSP_W    = ADC_BITS * N_COLS;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_READ  = 2'b01,
        OP_MAC   = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_WR,
        S_EVAL,
        S_SENSE,
        S_RESP
    } state_e;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    function automatic logic [N_ROWS-1:0] onehot_row(input logic [3:0] row);
        return N_ROWS'(1) << row;
    endfunction
endpackage

// File: rtl/cim_macro_seq_if.sv
// Command/response handshake between a host and the CIM macro sequencer.
interface cim_macro_seq_if;
    import cim_seq_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [3:0]        cmd_row;
    logic [N_COLS-1:0] cmd_data;
    logic              rsp_valid;
    logic [1:0]        rsp_op;
    logic              rsp_err;
    logic [RSP_W-1:0]  rsp_data;

    modport master (
        output cmd_valid, cmd_op, cmd_row, cmd_data,
        input  cmd_ready, rsp_valid, rsp_op, rsp_err, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_row, cmd_data,
        output cmd_ready, rsp_valid, rsp_op, rsp_err, rsp_data
    );
endinterface

// File: rtl/cim_phase_timer.sv
// Loadable down-counter; done_o marks the last cycle of a phase (count == 1).
module cim_phase_timer #(
    parameter int CNT_W = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             done_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturates at zero so an idle timer never wraps back into a live count.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign done_o = (cnt_q == CNT_W'(1));
endmodule

// File: rtl/cim_macro_seq.sv
// Phase sequencer for the 16x16 CIM macro: WRITE / READ / MAC over valid/ready,
// Moore-decoded wordlines and strobes, registered response.
module cim_macro_seq
    import cim_seq_pkg::*;
#(
    parameter int T_PRE   = 2,
    parameter int T_WR    = 2,
    parameter int T_EVAL  = 3,
    parameter int T_SENSE = 1
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    cim_macro_seq_if.slave    bus,
    output logic [N_ROWS-1:0] WWL,
    output logic [N_ROWS-1:0] RWL,
    output logic [N_ROWS-1:0] RWLB,
    output logic [N_COLS-1:0] Din,
    output logic              WE,
    output logic              PRE_SRAM,
    output logic              PRE_VLSA,
    output logic              PRE_CLSA,
    output logic              PRE_A,
    output logic              SAEN,
    output logic              VCLP,
    output logic              EN,
    input  logic [N_COLS-1:0] SA_OUT,
    input  logic [RSP_W-1:0]  adc_out
);
    localparam int CNT_W = $clog2(max4(T_PRE, T_WR, T_EVAL, T_SENSE)) + 1;

    state_e            state_q, state_d;
    op_e               op_q;
    logic [3:0]        row_q;
    logic [N_COLS-1:0] data_q;
    logic [1:0]        rsp_op_q;
    logic              rsp_err_q;
    logic [RSP_W-1:0]  rsp_data_q;
    logic              tmr_load, tmr_done;
    logic [CNT_W-1:0]  tmr_val;
    logic              accept;

    assign accept = (state_q == S_IDLE) && bus.cmd_valid;

    cim_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk_i      (wb_clk_i),
        .rst_i      (wb_rst_i),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .done_o     (tmr_done)
    );

    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        unique case (state_q)
            S_IDLE: if (bus.cmd_valid) begin
                if (op_e'(bus.cmd_op) == OP_RSVD) begin
                    state_d = S_RESP;
                end else begin
                    state_d  = S_PRE;
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(T_PRE);
                end
            end
            S_PRE: if (tmr_done) begin
                tmr_load = 1'b1;
                if (op_q == OP_WRITE) begin
                    state_d = S_WR;
                    tmr_val = CNT_W'(T_WR);
                end else begin
                    state_d = S_EVAL;
                    tmr_val = CNT_W'(T_EVAL);
                end
            end
            S_WR:   if (tmr_done) state_d = S_RESP;
            S_EVAL: if (tmr_done) begin
                state_d  = S_SENSE;
                tmr_load = 1'b1;
                tmr_val  = CNT_W'(T_SENSE);
            end
            S_SENSE: if (tmr_done) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes decode purely from state, so a reset edge drops them immediately.
    always_comb begin
        WWL = '0; RWL = '0; RWLB = '0; Din = '0;
        WE = 1'b0; PRE_SRAM = 1'b0; PRE_VLSA = 1'b0; PRE_CLSA = 1'b0;
        PRE_A = 1'b0; SAEN = 1'b0; VCLP = 1'b0; EN = 1'b0;
        unique case (state_q)
            S_PRE: begin
                PRE_SRAM = 1'b1;
                PRE_VLSA = (op_q == OP_READ);
                PRE_CLSA = (op_q == OP_MAC);
                PRE_A    = (op_q == OP_MAC);
            end
            S_WR: begin
                WWL = onehot_row(row_q);
                WE  = 1'b1;
                Din = data_q;
            end
            S_EVAL, S_SENSE: begin
                if (op_q == OP_MAC) begin
                    RWL  = data_q;
                    RWLB = ~data_q;
                    EN   = 1'b1;
                    VCLP = 1'b1;
                end else begin
                    RWL  = onehot_row(row_q);
                    SAEN = (state_q == S_SENSE);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (accept) begin
            op_q   <= op_e'(bus.cmd_op);
            row_q  <= bus.cmd_row;
            data_q <= bus.cmd_data;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= S_IDLE;
            rsp_op_q   <= '0;
            rsp_err_q  <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept && op_e'(bus.cmd_op) == OP_RSVD) begin
                rsp_op_q   <= OP_RSVD;
                rsp_err_q  <= 1'b1;
                rsp_data_q <= '0;
            end else if (state_q == S_WR && tmr_done) begin
                rsp_op_q   <= OP_WRITE;
                rsp_err_q  <= 1'b0;
                rsp_data_q <= '0;
            end else if (state_q == S_SENSE && tmr_done) begin
                rsp_op_q   <= op_q;
                rsp_err_q  <= 1'b0;
                rsp_data_q <= (op_q == OP_MAC) ? adc_out
                                               : {{(RSP_W-N_COLS){1'b0}}, SA_OUT};
            end
        end
    end

    assign bus.cmd_ready = (state_q == S_IDLE);
    assign bus.rsp_valid = (state_q == S_RESP);
    assign bus.rsp_op    = rsp_op_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_data  = rsp_data_q;
endmodule

// File: doc/cim_macro_seq.md
Name: cim_macro_seq

Overview:
- Synchronous sequencer directly upstream of the 16x16 CIM bitcell/ADC macro.
- Accepts WRITE, READ and MAC commands over a valid/ready handshake.
- Drives the macro's wordlines, data and precharge/sense/enable strobes in fixed, parameterised phases.
- Captures SA_OUT or the sixteen 4-bit ADC results into a registered response.

Parameters:
T_PRE, 2, precharge phase length in cycles (>=1)
T_WR, 2, write-wordline phase length in cycles (>=1)
T_EVAL, 3, read-wordline evaluate phase length in cycles (>=1)
T_SENSE, 1, sense/ADC-enable phase length in cycles (>=1)

Ports:
wb_clk_i in 1 clock; the only clock
wb_rst_i in 1 reset, synchronous, active-high
cmd_valid in 1 command offered
cmd_ready out 1 high only in IDLE
cmd_op in 2 00 WRITE, 01 READ, 10 MAC, 11 reserved
cmd_row in 4 target row for WRITE/READ
cmd_data in 16 write data (WRITE) or input vector x (MAC)
WWL out 16 write wordlines
RWL out 16 read wordlines
RWLB out 16 complementary read wordlines
Din out 16 write data to macro
WE, PRE_SRAM, PRE_VLSA, PRE_CLSA, PRE_A, SAEN, VCLP, EN out 1 each, macro strobes
SA_OUT in 16 sense-amp outputs from macro
adc_out in 64 ADC results packed {ADC15..ADC0}, 4 bits each
rsp_valid out 1 one-cycle response pulse
rsp_op out 2 op of the completed command
rsp_err out 1 reserved op
rsp_data out 64 READ: {48'b0,SA_OUT}; MAC: adc_out; WRITE/err: 0

Behaviour:
- Reset (synchronous, wb_rst_i high at edge): FSM to IDLE, all outputs 0 except cmd_ready=1. Applies mid-operation too: wordlines and strobes drop at that edge, and no rsp_valid is issued for the aborted command.
- Accept: cmd_valid && cmd_ready at edge. cmd_op, cmd_row and cmd_data are registered. Inputs are ignored at all other times.
- FSM states: IDLE, PRE, WR, EVAL, SENSE, RESP. Phase length comes from a down-counter loaded on entry.
- IDLE:
  - WRITE/READ/MAC accepted -> PRE.
  - Op 11 accepted -> RESP with rsp_err=1; no macro strobes toggle.
- PRE, for T_PRE cycles:
  - WRITE: PRE_SRAM=1.
  - READ: PRE_SRAM=1 and PRE_VLSA=1.
  - MAC: PRE_SRAM, PRE_CLSA and PRE_A =1.
  - Exit: WRITE -> WR; READ/MAC -> EVAL.
- WR, for T_WR cycles: WWL = one-hot(row), WE=1, Din=data. Then -> RESP.
- EVAL, for T_EVAL cycles:
  - READ: RWL = one-hot(row), RWLB=0.
  - MAC: RWL=x, RWLB=~x, EN=1, VCLP=1.
  - Then -> SENSE.
- SENSE, for T_SENSE cycles:
  - Wordlines held as in EVAL.
  - READ: SAEN=1.
  - MAC: EN=1, VCLP=1.
  - At the edge ending the last SENSE cycle, rsp_data captures SA_OUT or adc_out.
- RESP, exactly 1 cycle:
  - rsp_valid=1; all strobes and wordlines 0.
  - rsp_op, rsp_err and rsp_data held until the next response (or reset).
  - Then -> IDLE.
- No response backpressure; rsp_valid is a pulse the consumer must sample.
- Mutual exclusion invariants: no WWL bit is high while any RWL/RWLB bit is high; precharge strobes are never high together with WE, SAEN or EN; at most one WWL bit is high.
- Latency from accept edge to rsp_valid cycle:
  - WRITE: T_PRE+T_WR+1 (defaults: 5).
  - READ/MAC: T_PRE+T_EVAL+T_SENSE+1 (defaults: 7).
  - Reserved op: 1.
- Throughput: next accept is possible the cycle after RESP (cmd_ready high in IDLE). cmd_valid held high through RESP is accepted on the first IDLE cycle.
- Counter width: clog2 of the maximum parameter plus 1; counter never wraps.

Decomposition:
- Package cim_seq_pkg: op encodings (OP_WRITE, OP_READ, OP_MAC, OP_RSVD), state enum, ADC_BITS=4, N_COLS=16, N_ROWS=16.
- One sub-module, cim_phase_timer: loadable down-counter with load value, load strobe and a done flag when count==1.

Test Plan:
- Reset during EVAL of a READ (row 5) -> RWL=0, SAEN=0 and IDLE on the next edge; no rsp_valid; cmd_ready=1.
- WRITE row 3, data 16'hA5C3 (defaults):
  - PRE_SRAM high for 2 cycles.
  - Then WWL=16'h0008, WE=1, Din=16'hA5C3 for 2 cycles.
  - rsp_valid 5 cycles after accept, rsp_data=0.
- READ row 15, bench macro drives SA_OUT=16'h1234 during SENSE:
  - PRE_SRAM/PRE_VLSA high for 2 cycles.
  - Then RWL=16'h8000 for 4 cycles, SAEN only in the last.
  - rsp_valid at cycle 7, rsp_data=64'h1234, rsp_op=01.
- MAC x=16'h00FF, adc_out=64'hFEDC_BA98_7654_3210 during SENSE:
  - RWL=16'h00FF, RWLB=16'hFF00, EN=1.
  - rsp_data=64'hFEDC_BA98_7654_3210, rsp_op=10.
- Op 11 accepted -> rsp_valid next cycle with rsp_err=1; WWL/RWL/strobes stay 0 throughout.
- cmd_valid held high across WRITE then READ back-to-back -> second accept on the cycle after RESP; assertions on every cycle confirm the invariants above.
